ft2232_fifo_responder: RTL and testbench
========================================

Name: ft2232_fifo_responder

Overview:
- Synthesizable device-side responder for the FT2232H 245-style synchronous FIFO bus. It is the other end of the FPGA FIFO controller.
- Supplies RXF#/TXE# status, serves reads from an RX buffer (host→FPGA) and accepts writes into a TX buffer (FPGA→host).
- Host-side byte ports let a bench or a loopback harness inject and drain data.
- Can emulate USB packet-boundary TXE# gaps, so the controller's stall and turnaround paths get exercised.

Parameters:
- RX_ASIZE, 4, log2 depth of RX buffer (host→FPGA).
- TX_ASIZE, 4, log2 depth of TX buffer (FPGA→host).
- TXE_GAP_EVERY, 0, accepted TX bytes between forced TXE# gaps; 0 disables gaps.
- TXE_GAP_CYCLES, 4, length of each forced TXE# gap in clocks (≥1).

Ports:
- fifo_clk_i  in  1  bus clock; all logic on its rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- ft2232_reset_n_i  in  1  device reset from controller; low = synchronous flush.
- fifo_oe_n_i  in  1  bus output enable from controller.
- fifo_rd_n_i  in  1  read strobe.
- fifo_wr_n_i  in  1  write strobe.
- fifo_siwu_i  in  1  send-immediate; ignored, 1 expected.
- fifo_data_i  in  8  bus value driven by controller.
- fifo_data_o  out  8  bus value driven by responder.
- fifo_data_oe_o  out  1  responder bus drive enable (tristate control at top level).
- fifo_rxf_n_o  out  1  low = read data available.
- fifo_txe_n_o  out  1  low = write space available.
- host_wr_en_i  in  1  push host_wr_data_i into RX buffer.
- host_wr_data_i  in  8  host byte.
- host_full_o  out  1  RX buffer full.
- host_rd_en_i  in  1  pop TX buffer.
- host_rd_data_o  out  8  TX head byte (first-word fall-through).
- host_empty_o  out  1  TX buffer empty.
- tx_overflow_o  out  1  sticky: write dropped because TX buffer full.
- protocol_err_o  out  1  sticky: illegal strobe combination seen.

Behaviour:
- Reset (reset_i, or ft2232_reset_n_i=0 sampled synchronously):
  - Both buffers empty.
  - fifo_data_o=0, fifo_data_oe_o=0, fifo_rxf_n_o=1, fifo_txe_n_o=1.
  - host_full_o=0, host_empty_o=1, sticky flags 0, gap FSM in TX_OPEN with counters 0.
- Bus direction FSM, states BUS_HIZ and BUS_DRIVE:
  - Edge sampling oe_n_i=0 → BUS_DRIVE.
  - Edge sampling oe_n_i=1 → BUS_HIZ.
  - fifo_data_oe_o is 1 only in BUS_DRIVE, giving a one-cycle turnaround after OE# changes.
- Read: a pop occurs on the edge where rd_n_i=0, oe_n_i=0 and fifo_rxf_n_o=0.
  - The head byte moves into the fifo_data_o register and is valid for the following cycle (read latency 1).
  - Consecutive pops stream one byte per clock.
  - rd_n_i=0 with rxf_n_o=1 is ignored. No pop, no error.
- fifo_rxf_n_o is registered. Next value = 1 only if the RX count after this edge is 0 and no pop happened on this edge.
  - So RXF# stays low during the cycle the last byte is valid, then rises.
- Write: a push occurs on the edge where wr_n_i=0 and oe_n_i=1.
  - TXE# is not re-checked at this edge, so one in-flight write is accepted.
  - If the TX buffer is full, the byte is dropped and tx_overflow_o is set.
- fifo_txe_n_o is registered. Next value = 1 when free TX entries after this edge < 2, or the gap FSM is in TX_GAP. Otherwise 0.
- Gap FSM (only when TXE_GAP_EVERY≠0):
  - TX_OPEN counts accepted pushes. On reaching TXE_GAP_EVERY it enters TX_GAP and the counter clears.
  - TX_GAP holds for TXE_GAP_CYCLES clocks, then returns to TX_OPEN.
  - A write arriving during a gap but issued against the prior TXE#=0 is still accepted.
- protocol_err_o is set on any edge where:
  - rd_n_i=0 and wr_n_i=0, or
  - wr_n_i=0 and oe_n_i=0, or
  - rd_n_i=0 and oe_n_i=1.
  - No push or pop occurs on that edge.
- Host side:
  - host_wr_en_i while full → ignored.
  - host_rd_en_i while empty → ignored.
  - Simultaneous host push and bus pop (or bus push and host pop) are both honoured; counts stay exact.
- Counts are ASIZE+1 bits, pointers ASIZE bits and wrap naturally.
- Reset mid-burst: flush takes effect at that edge. In-flight bytes are lost. Status returns to the reset values.

Decomposition:
- Package ft2232_pkg holds:
  - bus FSM enum (BUS_HIZ, BUS_DRIVE);
  - gap FSM enum (TX_OPEN, TX_GAP);
  - shared byte typedef;
  - TXE slack constant (2).
- Sub-module ft2232_model_buf: single-clock FWFT FIFO with ASIZE parameter, push/pop/flush, count, full/empty. Instantiated twice.

Test Plan:
- Host pushes 0x11,0x22,0x33; controller sets OE# low, then RD# low 1 cycle later for 4 clocks → bus shows 0x11,0x22,0x33 on 3 consecutive cycles; RXF# rises the cycle after 0x33 is valid; 4th strobe causes no pop.
- Controller writes 0x00..0x0E with RX empty, TX_ASIZE=4 → TXE# high after 15th push; a 16th in-flight write of 0x0F is accepted; a 17th is dropped and tx_overflow_o=1; host drains 0x00..0x0F in order.
- TXE_GAP_EVERY=8, TXE_GAP_CYCLES=4, continuous writes → TXE# high for exactly 4 clocks after every 8th accepted byte; no byte lost.
- OE# toggles low→high→low → fifo_data_oe_o follows one cycle later each time; never 1 while OE# sampled high.
- wr_n_i=0 while oe_n_i=0 → protocol_err_o=1, TX count unchanged.
- ft2232_reset_n_i low for 1 cycle with 5 bytes in each buffer → both empty, RXF#=1, TXE#=1 for one cycle, then TXE#=0.

Source files
------------

// File: rtl/ft2232_pkg.sv
// Shared types and constants for the FT2232H synchronous-FIFO device model.
package ft2232_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [0:0] {
    BUS_HIZ   = 1'b0,
    BUS_DRIVE = 1'b1
  } bus_state_t;

  typedef enum logic [0:0] {
    TX_OPEN = 1'b0,
    TX_GAP  = 1'b1
  } gap_state_t;

  // TXE# deasserts while fewer than this many TX entries are free, leaving
  // room for the one write the controller may already have in flight.
  localparam int TXE_SLACK = 2;

endpackage

// File: rtl/ft2232_model_buf.sv
// Single-clock first-word-fall-through byte FIFO with synchronous flush.
// count_next exposes the occupancy that will hold after the current edge.
module ft2232_model_buf
  import ft2232_pkg::*;
#(
  parameter int ASIZE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  byte_t        push_data,
  input  logic         pop,
  output byte_t        head,
  output logic [ASIZE:0] count_next,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] COUNT_ONE = (ASIZE+1)'(1);
  localparam logic [ASIZE-1:0] PTR_ONE = ASIZE'(1);

  byte_t            mem [DEPTH];
  logic [ASIZE-1:0] wr_ptr;
  logic [ASIZE-1:0] rd_ptr;
  logic [ASIZE:0]   count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (ASIZE+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   count_next = count + COUNT_ONE;
        2'b01:   count_next = count - COUNT_ONE;
        default: count_next = count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_next;
    end
  end

endmodule

// File: rtl/ft2232_fifo_responder.sv
// Device-side FT2232H 245 synchronous FIFO responder: serves controller reads
// from an RX buffer, accepts controller writes into a TX buffer.
module ft2232_fifo_responder
  import ft2232_pkg::*;
#(
  parameter int RX_ASIZE       = 4,
  parameter int TX_ASIZE       = 4,
  parameter int TXE_GAP_EVERY  = 0,
  parameter int TXE_GAP_CYCLES = 4
) (
  input  logic       fifo_clk_i,
  input  logic       reset_i,
  input  logic       ft2232_reset_n_i,
  input  logic       fifo_oe_n_i,
  input  logic       fifo_rd_n_i,
  input  logic       fifo_wr_n_i,
  input  logic       fifo_siwu_i,
  input  logic [7:0] fifo_data_i,
  output logic [7:0] fifo_data_o,
  output logic       fifo_data_oe_o,
  output logic       fifo_rxf_n_o,
  output logic       fifo_txe_n_o,
  input  logic       host_wr_en_i,
  input  logic [7:0] host_wr_data_i,
  output logic       host_full_o,
  input  logic       host_rd_en_i,
  output logic [7:0] host_rd_data_o,
  output logic       host_empty_o,
  output logic       tx_overflow_o,
  output logic       protocol_err_o
);

  localparam logic [TX_ASIZE:0] TX_DEPTH = (TX_ASIZE+1)'(1 << TX_ASIZE);
  localparam logic [15:0] GAP_EVERY_LAST  = 16'(TXE_GAP_EVERY - 1);
  localparam logic [15:0] GAP_CYCLES_LAST = 16'(TXE_GAP_CYCLES - 1);

  logic flush;
  logic strobe_err;
  logic bus_pop;
  logic bus_push;
  logic tx_push_ok;

  byte_t              rx_head;
  logic [RX_ASIZE:0]  rx_count_next;
  logic               rx_full;
  logic               rx_empty;
  logic [TX_ASIZE:0]  tx_count_next;
  logic [TX_ASIZE:0]  tx_free_next;
  logic               tx_full;

  bus_state_t  bus_state;
  gap_state_t  gap_state;
  gap_state_t  gap_next;
  logic [15:0] push_cnt;
  logic [15:0] push_cnt_next;
  logic [15:0] gap_cnt;
  logic [15:0] gap_cnt_next;

  // SIWU has no effect on this model.
  logic unused_siwu;
  assign unused_siwu = fifo_siwu_i;

  assign flush      = !ft2232_reset_n_i;
  assign strobe_err = (!fifo_rd_n_i && !fifo_wr_n_i) ||
                      (!fifo_wr_n_i && !fifo_oe_n_i) ||
                      (!fifo_rd_n_i &&  fifo_oe_n_i);
  // rx_empty guards the edge after the last pop, where RXF# is still low.
  assign bus_pop    = !fifo_rd_n_i && !fifo_oe_n_i && !fifo_rxf_n_o &&
                      !rx_empty && !strobe_err;
  assign bus_push   = !fifo_wr_n_i && fifo_oe_n_i && !strobe_err;
  assign tx_push_ok = bus_push && !tx_full;

  assign fifo_data_oe_o = (bus_state == BUS_DRIVE);
  assign host_full_o    = rx_full;
  assign tx_free_next   = TX_DEPTH - tx_count_next;

  ft2232_model_buf #(.ASIZE(RX_ASIZE)) u_rx_buf (
    .clk        (fifo_clk_i),
    .rst        (reset_i),
    .flush      (flush),
    .push       (host_wr_en_i),
    .push_data  (host_wr_data_i),
    .pop        (bus_pop),
    .head       (rx_head),
    .count_next (rx_count_next),
    .full       (rx_full),
    .empty      (rx_empty)
  );

  ft2232_model_buf #(.ASIZE(TX_ASIZE)) u_tx_buf (
    .clk        (fifo_clk_i),
    .rst        (reset_i),
    .flush      (flush),
    .push       (bus_push),
    .push_data  (fifo_data_i),
    .pop        (host_rd_en_i),
    .head       (host_rd_data_o),
    .count_next (tx_count_next),
    .full       (tx_full),
    .empty      (host_empty_o)
  );

  // Gap FSM: only pushes accepted while open count toward the next gap.
  always_comb begin
    gap_next      = gap_state;
    push_cnt_next = push_cnt;
    gap_cnt_next  = gap_cnt;
    if (TXE_GAP_EVERY != 0) begin
      case (gap_state)
        TX_OPEN: begin
          if (tx_push_ok) begin
            if (push_cnt == GAP_EVERY_LAST) begin
              gap_next      = TX_GAP;
              push_cnt_next = '0;
              gap_cnt_next  = '0;
            end else begin
              push_cnt_next = push_cnt + 16'd1;
            end
          end
        end
        TX_GAP: begin
          if (gap_cnt == GAP_CYCLES_LAST) begin
            gap_next     = TX_OPEN;
            gap_cnt_next = '0;
          end else begin
            gap_cnt_next = gap_cnt + 16'd1;
          end
        end
        default: gap_next = TX_OPEN;
      endcase
    end
  end

  always_ff @(posedge fifo_clk_i or posedge reset_i) begin
    if (reset_i) begin
      bus_state      <= BUS_HIZ;
      gap_state      <= TX_OPEN;
      push_cnt       <= '0;
      gap_cnt        <= '0;
      fifo_data_o    <= '0;
      fifo_rxf_n_o   <= 1'b1;
      fifo_txe_n_o   <= 1'b1;
      tx_overflow_o  <= 1'b0;
      protocol_err_o <= 1'b0;
    end else if (flush) begin
      bus_state      <= BUS_HIZ;
      gap_state      <= TX_OPEN;
      push_cnt       <= '0;
      gap_cnt        <= '0;
      fifo_data_o    <= '0;
      fifo_rxf_n_o   <= 1'b1;
      fifo_txe_n_o   <= 1'b1;
      tx_overflow_o  <= 1'b0;
      protocol_err_o <= 1'b0;
    end else begin
      bus_state <= fifo_oe_n_i ? BUS_HIZ : BUS_DRIVE;
      gap_state <= gap_next;
      push_cnt  <= push_cnt_next;
      gap_cnt   <= gap_cnt_next;
      if (bus_pop) fifo_data_o <= rx_head;
      fifo_rxf_n_o <= (rx_count_next == '0) && !bus_pop;
      fifo_txe_n_o <= (tx_free_next < (TX_ASIZE+1)'(TXE_SLACK)) || (gap_next == TX_GAP);
      if (bus_push && tx_full) tx_overflow_o <= 1'b1;
      if (strobe_err) protocol_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ft2232_fifo_responder.sv
// Directed bench for ft2232_fifo_responder: one instance without TXE# gaps,
// one with a gap every 8 accepted bytes.
module tb_ft2232_fifo_responder;

  logic clk;
  logic reset;

  logic       rst_n, oe_n, rd_n, wr_n, siwu;
  logic [7:0] wdata;
  logic [7:0] data_o;
  logic       data_oe, rxf_n, txe_n;
  logic       host_wr_en, host_rd_en;
  logic [7:0] host_wr_data, host_rd_data;
  logic       host_full, host_empty, overflow, perr;

  logic       rst_n_b, oe_n_b, rd_n_b, wr_n_b, siwu_b;
  logic [7:0] wdata_b;
  logic [7:0] data_o_b;
  logic       data_oe_b, rxf_n_b, txe_n_b;
  logic       host_wr_en_b, host_rd_en_b;
  logic [7:0] host_wr_data_b, host_rd_data_b;
  logic       host_full_b, host_empty_b, overflow_b, perr_b;

  int passed = 0;
  int total  = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] gap_q[$];

  ft2232_fifo_responder #(
    .RX_ASIZE(4), .TX_ASIZE(4), .TXE_GAP_EVERY(0), .TXE_GAP_CYCLES(4)
  ) dut (
    .fifo_clk_i(clk), .reset_i(reset), .ft2232_reset_n_i(rst_n),
    .fifo_oe_n_i(oe_n), .fifo_rd_n_i(rd_n), .fifo_wr_n_i(wr_n),
    .fifo_siwu_i(siwu), .fifo_data_i(wdata), .fifo_data_o(data_o),
    .fifo_data_oe_o(data_oe), .fifo_rxf_n_o(rxf_n), .fifo_txe_n_o(txe_n),
    .host_wr_en_i(host_wr_en), .host_wr_data_i(host_wr_data),
    .host_full_o(host_full), .host_rd_en_i(host_rd_en),
    .host_rd_data_o(host_rd_data), .host_empty_o(host_empty),
    .tx_overflow_o(overflow), .protocol_err_o(perr)
  );

  ft2232_fifo_responder #(
    .RX_ASIZE(4), .TX_ASIZE(4), .TXE_GAP_EVERY(8), .TXE_GAP_CYCLES(4)
  ) dut_gap (
    .fifo_clk_i(clk), .reset_i(reset), .ft2232_reset_n_i(rst_n_b),
    .fifo_oe_n_i(oe_n_b), .fifo_rd_n_i(rd_n_b), .fifo_wr_n_i(wr_n_b),
    .fifo_siwu_i(siwu_b), .fifo_data_i(wdata_b), .fifo_data_o(data_o_b),
    .fifo_data_oe_o(data_oe_b), .fifo_rxf_n_o(rxf_n_b), .fifo_txe_n_o(txe_n_b),
    .host_wr_en_i(host_wr_en_b), .host_wr_data_i(host_wr_data_b),
    .host_full_o(host_full_b), .host_rd_en_i(host_rd_en_b),
    .host_rd_data_o(host_rd_data_b), .host_empty_o(host_empty_b),
    .tx_overflow_o(overflow_b), .protocol_err_o(perr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] last_rd;
    logic [7:0] d;
    int run_len;
    int gap_len;
    int budget;

    reset = 1'b1;
    rst_n = 1'b1; oe_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; siwu = 1'b1; wdata = '0;
    host_wr_en = 1'b0; host_wr_data = '0; host_rd_en = 1'b0;
    rst_n_b = 1'b1; oe_n_b = 1'b1; rd_n_b = 1'b1; wr_n_b = 1'b1; siwu_b = 1'b1; wdata_b = '0;
    host_wr_en_b = 1'b0; host_wr_data_b = '0; host_rd_en_b = 1'b1;
    last_rd = '0;

    // Reset state
    repeat (2) tick();
    check("rst_data_oe", 32'(data_oe), 32'd0);
    check("rst_rxf_n", 32'(rxf_n), 32'd1);
    check("rst_txe_n", 32'(txe_n), 32'd1);
    check("rst_host_full", 32'(host_full), 32'd0);
    check("rst_host_empty", 32'(host_empty), 32'd1);
    check("rst_data_o", 32'(data_o), 32'd0);
    check("rst_flags", 32'({overflow, perr}), 32'd0);
    reset = 1'b0;
    tick();
    check("txe_after_rst", 32'(txe_n), 32'd0);

    // Host to controller read burst
    for (int i = 0; i < 3; i++) begin
      host_wr_en = 1'b1;
      host_wr_data = 8'h11 * 8'(i + 1);
      rx_q.push_back(host_wr_data);
      tick();
    end
    host_wr_en = 1'b0;
    check("rxf_low_with_data", 32'(rxf_n), 32'd0);
    oe_n = 1'b0;
    tick();
    check("oe_drive_before_rd", 32'(data_oe), 32'd1);
    rd_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rx_q.size() != 0) begin
        last_rd = rx_q.pop_front();
        check("rd_data", 32'(data_o), 32'(last_rd));
        check("rd_rxf_low", 32'(rxf_n), 32'd0);
      end else begin
        check("rd_extra_no_pop", 32'(data_o), 32'(last_rd));
        check("rd_rxf_high", 32'(rxf_n), 32'd1);
      end
    end
    rd_n = 1'b1;
    oe_n = 1'b1;
    tick();
    check("rd_no_perr", 32'(perr), 32'd0);
    check("rd_hiz", 32'(data_oe), 32'd0);

    // OE# turnaround low -> high -> low -> high
    for (int i = 0; i < 4; i++) begin
      oe_n = (i % 2 == 1);
      check("oe_lag_old", 32'(data_oe), 32'(i % 2 == 1));
      tick();
      check("oe_follow", 32'(data_oe), 32'(i % 2 == 0));
    end
    oe_n = 1'b1;
    tick();

    // Controller fills TX buffer; 17th write overflows
    for (int i = 0; i < 17; i++) begin
      wr_n = 1'b0;
      wdata = 8'(i);
      if (i < 16) tx_q.push_back(wdata);
      tick();
      check($sformatf("tx_txe_n_%0d", i), 32'(txe_n), 32'(i >= 14));
      check($sformatf("tx_ovf_%0d", i), 32'(overflow), 32'(i == 16));
    end
    wr_n = 1'b1;
    host_rd_en = 1'b1;
    budget = 40;
    while (tx_q.size() != 0 && budget > 0) begin
      if (!host_empty) check("tx_drain", 32'(host_rd_data), 32'(tx_q.pop_front()));
      tick();
      budget--;
    end
    check("tx_drain_done", 32'(tx_q.size()), 32'd0);
    host_rd_en = 1'b0;
    check("tx_empty_after", 32'(host_empty), 32'd1);

    // Write while OE# low: protocol error, nothing pushed
    oe_n = 1'b0;
    wr_n = 1'b0;
    wdata = 8'hAA;
    tick();
    wr_n = 1'b1;
    oe_n = 1'b1;
    check("perr_set", 32'(perr), 32'd1);
    check("perr_no_push", 32'(host_empty), 32'd1);
    tick();

    // Flush with five bytes in each buffer
    for (int i = 0; i < 5; i++) begin
      host_wr_en = 1'b1;
      host_wr_data = 8'h40 + 8'(i);
      wr_n = 1'b0;
      wdata = 8'h50 + 8'(i);
      tick();
    end
    host_wr_en = 1'b0;
    wr_n = 1'b1;
    check("pre_flush_tx", 32'(host_empty), 32'd0);
    check("pre_flush_rx", 32'(rxf_n), 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("flush_rxf_n", 32'(rxf_n), 32'd1);
    check("flush_txe_n", 32'(txe_n), 32'd1);
    check("flush_empty", 32'(host_empty), 32'd1);
    check("flush_flags", 32'({overflow, perr}), 32'd0);
    check("flush_data_o", 32'(data_o), 32'd0);
    tick();
    check("post_flush_txe_n", 32'(txe_n), 32'd0);
    check("post_flush_rxf_n", 32'(rxf_n), 32'd1);
    check("post_flush_empty", 32'(host_empty), 32'd1);

    // Continuous writes into the gap instance, host draining every cycle
    d = '0;
    run_len = 0;
    gap_len = 0;
    for (int c = 0; c < 60; c++) begin
      if (!host_empty_b) begin
        if (gap_q.size() == 0) check("gap_extra_byte", 32'd1, 32'd0);
        else check("gap_data", 32'(host_rd_data_b), 32'(gap_q.pop_front()));
      end
      if (txe_n_b == 1'b0) begin
        if (gap_len != 0) begin
          check("gap_len", 32'(gap_len), 32'd4);
          gap_len = 0;
        end
        wr_n_b = 1'b0;
        wdata_b = d;
        gap_q.push_back(d);
        d++;
        run_len++;
      end else begin
        if (run_len != 0) begin
          check("gap_run_len", 32'(run_len), 32'd8);
          run_len = 0;
        end
        wr_n_b = 1'b1;
        gap_len++;
      end
      tick();
    end
    wr_n_b = 1'b1;
    budget = 10;
    while (gap_q.size() != 0 && budget > 0) begin
      if (!host_empty_b) check("gap_drain", 32'(host_rd_data_b), 32'(gap_q.pop_front()));
      tick();
      budget--;
    end
    check("gap_no_loss", 32'(gap_q.size()), 32'd0);
    check("gap_empty", 32'(host_empty_b), 32'd1);
    check("gap_no_overflow", 32'(overflow_b), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
